pcileech_com_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares the single 256-bit com TX path (toward the FT601 com controller) among up to NUM_SRC dword producers, e.g. TLP, config, loopback and command return.
- Packs granted dwords into 7 data slots plus 1 status dword per 256-bit word.
- Sits between the producer-side FIFOs and the com din interface inside the FIFO controller domain.
- A timeout flushes partially filled words so low-rate traffic is not stranded.

---
 rtl/pcileech_com_tx_arbiter.sv | 172 +++++++++++++++++
 tb/tb_pcileech_com_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_com_tx_arbiter.sv
// pcileech_com_tx_arbiter
//   Round-robin arbiter sharing the 256-bit com TX path among NUM_SRC dword
//   producers. Granted dwords are packed into 7 data slots plus one status
//   dword {STATUS_MAGIC, tag6..tag0}. A word leaves when full, or after
//   TIMEOUT_CYCLES idle cycles with a partial fill.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   arb_en           enables new grants (in-flight words still drain)
//   src_data/valid   per-source FWFT dword and valid, source i at [32*i+:32]
//   src_ack          combinational one-hot pop, dword captured at the same edge
//   dout/dout_valid  packed output word and its valid
//   dout_ready       consumer accepts dout when dout_valid && dout_ready
//   stat_words       count of accepted words (wraps)
module pcileech_com_tx_arbiter #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [3:0]  STATUS_MAGIC   = 4'hE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arb_en,
  input  logic [32*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]    src_valid,
  output logic [NUM_SRC-1:0]    src_ack,
  output logic [255:0]          dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [31:0]           stat_words
);

  localparam int unsigned DW     = 32;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned SLOTS  = 7;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TAG_W-1:0] TAG_EMPTY = 4'hF;

  logic [SLOTS-1:0][DW-1:0]    slot_q, slot_d;
  logic [SLOTS-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0]            slot_cnt_q, slot_cnt_d;
  logic [IDLE_W-1:0]           idle_cnt_q, idle_cnt_d;
  logic [TAG_W-1:0]            last_grant_q, last_grant_d;
  logic [255:0]                dout_q, dout_d;
  logic                        dout_valid_q, dout_valid_d;
  logic [31:0]                 stat_words_q, stat_words_d;

  logic                        found_c;
  logic [TAG_W-1:0]            winner_c;
  logic [DW-1:0]               win_data_c;
  int unsigned                 best_c, dist_c;
  logic                        full_c, ready_c, out_free_c, xfer_c, grant_c;
  logic [CNT_W-1:0]            wr_idx_c;
  logic [SLOTS-1:0][TAG_W-1:0] status_tags_c;
  logic [255:0]                word_c;

  // Round-robin pick: valid source at the smallest distance past last_grant.
  always_comb begin
    found_c    = 1'b0;
    winner_c   = '0;
    win_data_c = '0;
    best_c     = NUM_SRC;
    dist_c     = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      dist_c = (i + NUM_SRC - 1 - 32'(last_grant_q)) % NUM_SRC;
      if (src_valid[i] && (dist_c < best_c)) begin
        best_c     = dist_c;
        found_c    = 1'b1;
        winner_c   = TAG_W'(i);
        win_data_c = src_data[DW*i +: DW];
      end
    end
  end

  // Transfer/grant decisions. A grant is allowed on a full register only when
  // that word leaves at the same edge, which keeps 7 dwords per 7 cycles.
  always_comb begin
    full_c     = (slot_cnt_q == CNT_W'(SLOTS));
    ready_c    = full_c || (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES));
    out_free_c = !dout_valid_q || dout_ready;
    xfer_c     = ready_c && out_free_c;
    grant_c    = !rst && arb_en && found_c && (!full_c || xfer_c);
    wr_idx_c   = xfer_c ? '0 : slot_cnt_q;
    src_ack    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ack[i] = grant_c && (winner_c == TAG_W'(i));
    end
  end

  // Outgoing word: unused slots zeroed and tagged empty.
  always_comb begin
    word_c        = '0;
    status_tags_c = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      if (CNT_W'(k) < slot_cnt_q) begin
        word_c[DW*k +: DW] = slot_q[k];
        status_tags_c[k]   = tag_q[k];
      end else begin
        status_tags_c[k]   = TAG_EMPTY;
      end
    end
    word_c[255:224] = {STATUS_MAGIC, status_tags_c};
  end

  // Next-state for assembly and output registers.
  always_comb begin
    slot_d       = slot_q;
    tag_d        = tag_q;
    slot_cnt_d   = slot_cnt_q;
    idle_cnt_d   = idle_cnt_q;
    last_grant_d = last_grant_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    stat_words_d = stat_words_q;

    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
      stat_words_d = stat_words_q + 32'd1;
    end

    // idle_cnt saturates at the timeout so the word stays ready until it moves
    if (xfer_c) begin
      dout_d       = word_c;
      dout_valid_d = 1'b1;
      slot_cnt_d   = '0;
      idle_cnt_d   = '0;
    end else if ((slot_cnt_q == '0) || full_c) begin
      idle_cnt_d   = '0;
    end else if (!grant_c && (idle_cnt_q != IDLE_W'(TIMEOUT_CYCLES))) begin
      idle_cnt_d   = idle_cnt_q + IDLE_W'(1);
    end

    if (grant_c) begin
      for (int unsigned k = 0; k < SLOTS; k++) begin
        if (CNT_W'(k) == wr_idx_c) begin
          slot_d[k] = win_data_c;
          tag_d[k]  = winner_c;
        end
      end
      slot_cnt_d   = wr_idx_c + CNT_W'(1);
      idle_cnt_d   = '0;
      last_grant_d = winner_c;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q       <= '0;
      tag_q        <= '0;
      slot_cnt_q   <= '0;
      idle_cnt_q   <= '0;
      last_grant_q <= TAG_W'(NUM_SRC - 1);
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      stat_words_q <= '0;
    end else begin
      slot_q       <= slot_d;
      tag_q        <= tag_d;
      slot_cnt_q   <= slot_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      last_grant_q <= last_grant_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      stat_words_q <= stat_words_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign stat_words = stat_words_q;

endmodule

// File: tb/tb_pcileech_com_tx_arbiter.sv
// Scoreboard bench for pcileech_com_tx_arbiter: per-source dword queues feed
// the DUT, expected acks and expected words are queued as stimulus is set up
// and compared as the DUT acks and presents words.
module tb_pcileech_com_tx_arbiter;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned TIMEOUT = 64;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  arb_en;
  logic [32*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    src_ack;
  logic [255:0]          dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [31:0]           stat_words;

  pcileech_com_tx_arbiter #(
    .NUM_SRC       (NUM_SRC),
    .TIMEOUT_CYCLES(TIMEOUT),
    .STATUS_MAGIC  (4'hE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .arb_en    (arb_en),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_ack   (src_ack),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .stat_words(stat_words)
  );

  always #5 clk = ~clk;

  logic [31:0]        src_q [NUM_SRC][$];
  logic [255:0]       exp_words[$];
  int                 exp_ack[$];
  int                 n_checks, n_pass;
  int                 cyc, acks_seen, last_ack_cyc, dv_rise_cyc;
  logic               prev_dv;
  logic [NUM_SRC-1:0] pend_ack;
  logic               en_drv, rdy_drv;
  logic [6:0][31:0]   wd;
  logic [31:0]        d4 [21];

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_state();
    for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
    exp_words.delete();
    exp_ack.delete();
    pend_ack  = '0;
    acks_seen = 0;
    prev_dv   = 1'b0;
  endtask

  // One cycle: retire last cycle's pops, drive inputs at negedge, sample 1ns later.
  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NUM_SRC; i++)
      if (pend_ack[i] && (src_q[i].size() > 0)) void'(src_q[i].pop_front());
    pend_ack = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_valid[i]         = (src_q[i].size() > 0);
      src_data[32*i +: 32] = (src_q[i].size() > 0) ? src_q[i][0] : 32'd0;
    end
    arb_en     = en_drv;
    dout_ready = rdy_drv;
    #1;
    if (src_ack != '0) begin
      check_eq("ack_onehot", 256'($onehot(src_ack)), 256'd1);
      check_eq("ack_expected", 256'(exp_ack.size() != 0), 256'd1);
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_ack[i] && (exp_ack.size() != 0))
          check_eq("ack_src", 256'(i), 256'(exp_ack.pop_front()));
      end
      pend_ack     = src_ack;
      acks_seen++;
      last_ack_cyc = cyc;
    end
    if (dout_valid && !prev_dv) dv_rise_cyc = cyc;
    prev_dv = dout_valid;
    if (dout_valid) begin
      check_eq("word_expected", 256'(exp_words.size() != 0), 256'd1);
      if (exp_words.size() != 0) begin
        if (dout_ready) check_eq("word", dout, exp_words.pop_front());
        else            check_eq("word_hold", dout, exp_words[0]);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_state();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int max_cyc);
    int t = 0;
    while ((exp_words.size() != 0) && (t < max_cyc)) begin
      tick();
      t++;
    end
    check_eq(tag, 256'(exp_words.size()), 256'd0);
  endtask

  task automatic wait_acks(input string tag, input int n, input int max_cyc);
    int t = 0;
    while ((acks_seen < n) && (t < max_cyc)) begin
      tick();
      t++;
    end
    check_eq(tag, 256'(acks_seen), 256'(n));
  endtask

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; last_ack_cyc = 0; dv_rise_cyc = 0;
    rst = 1'b1; arb_en = 1'b0; dout_ready = 1'b0; src_valid = '0; src_data = '0;
    en_drv = 1'b1; rdy_drv = 1'b1; pend_ack = '0; prev_dv = 1'b0; acks_seen = 0;

    // Reset state
    do_reset();
    check_eq("rst_dout", dout, 256'd0);
    check_eq("rst_dout_valid", 256'(dout_valid), 256'd0);
    check_eq("rst_stat_words", 256'(stat_words), 256'd0);

    // T1: source 0 alone, 7 dwords
    for (int k = 0; k < 7; k++) begin
      src_q[0].push_back(32'(k + 1));
      exp_ack.push_back(0);
      wd[k] = 32'(k + 1);
    end
    exp_words.push_back({32'hE000_0000, wd});
    wait_words("t1_word_timeout", 40);
    check_eq("t1_latency", 256'(dv_rise_cyc - last_ack_cyc), 256'd2);
    tick();
    check_eq("t1_stat_words", 256'(stat_words), 256'd1);
    check_eq("t1_dout_valid_low", 256'(dout_valid), 256'd0);

    // T2: all four valid, round-robin from source 0
    do_reset();
    for (int n = 0; n < 7; n++) begin
      src_q[n % 4].push_back(32'hB000_0000 | 32'(n));
      exp_ack.push_back(n % 4);
      wd[n] = 32'hB000_0000 | 32'(n);
    end
    exp_words.push_back({32'hE210_3210, wd});
    wait_words("t2_word_timeout", 40);
    check_eq("t2_acks_left", 256'(exp_ack.size()), 256'd0);

    // T3: source 2 sends 3 dwords, word leaves on timeout
    do_reset();
    wd = '0;
    for (int k = 0; k < 3; k++) begin
      src_q[2].push_back(32'hC000_0001 + 32'(k));
      exp_ack.push_back(2);
      wd[k] = 32'hC000_0001 + 32'(k);
    end
    exp_words.push_back({32'hEFFF_F222, wd});
    wait_words("t3_word_timeout", 120);
    check_eq("t3_flush_latency", 256'(dv_rise_cyc - last_ack_cyc), 256'(TIMEOUT + 2));

    // T4: consumer stalls 20 cycles with all sources valid
    do_reset();
    for (int n = 0; n < 21; n++) begin
      d4[n] = 32'hA000_0000 | (32'(n % 4) << 16) | 32'(n);
      src_q[n % 4].push_back(d4[n]);
      exp_ack.push_back(n % 4);
    end
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 7; k++) wd[k] = d4[7*w + k];
      case (w)
        0:       exp_words.push_back({32'hE210_3210, wd});
        1:       exp_words.push_back({32'hE103_2103, wd});
        default: exp_words.push_back({32'hE032_1032, wd});
      endcase
    end
    rdy_drv = 1'b0;
    repeat (20) tick();
    check_eq("t4_stall_acks", 256'(acks_seen), 256'd14);
    check_eq("t4_stalled_ack", 256'(src_ack), 256'd0);
    check_eq("t4_stall_stat", 256'(stat_words), 256'd0);
    rdy_drv = 1'b1;
    tick();
    check_eq("t4_resume_grant", 256'(src_ack != '0), 256'd1);
    wait_words("t4_word_timeout", 40);
    check_eq("t4_total_acks", 256'(acks_seen), 256'd21);

    // T5: reset mid-word while a word is held on dout
    do_reset();
    for (int k = 0; k < 7; k++) begin
      src_q[0].push_back(32'hD000_0000 | 32'(k));
      exp_ack.push_back(0);
      wd[k] = 32'hD000_0000 | 32'(k);
    end
    exp_words.push_back({32'hE000_0000, wd});
    begin
      int t = 0;
      while ((stat_words != 32'd1) && (t < 40)) begin
        tick();
        t++;
      end
    end
    check_eq("t5_first_word", 256'(stat_words), 256'd1);
    rdy_drv = 1'b0;
    for (int k = 0; k < 11; k++) begin
      src_q[0].push_back(32'hD100_0000 | 32'(k));
      exp_ack.push_back(0);
      if (k < 7) wd[k] = 32'hD100_0000 | 32'(k);
    end
    exp_words.push_back({32'hE000_0000, wd});
    wait_acks("t5_fill_timeout", 18, 40);
    tick();
    check_eq("t5_held_valid", 256'(dout_valid), 256'd1);
    rst = 1'b1;
    src_valid = '1;
    #1;
    check_eq("t5_rst_dout", dout, 256'd0);
    check_eq("t5_rst_dout_valid", 256'(dout_valid), 256'd0);
    check_eq("t5_rst_src_ack", 256'(src_ack), 256'd0);
    check_eq("t5_rst_stat_words", 256'(stat_words), 256'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_state();
    rdy_drv = 1'b1;
    for (int k = 0; k < 2; k++) begin
      src_q[0].push_back(32'hE000_0010 | 32'(k));
      src_q[1].push_back(32'hE000_0020 | 32'(k));
    end
    for (int k = 0; k < 3; k++) src_q[3].push_back(32'hE000_0030 | 32'(k));
    exp_ack = '{0, 1, 3, 0, 1, 3, 3};
    wd[0] = 32'hE000_0010; wd[1] = 32'hE000_0020; wd[2] = 32'hE000_0030;
    wd[3] = 32'hE000_0011; wd[4] = 32'hE000_0021; wd[5] = 32'hE000_0031;
    wd[6] = 32'hE000_0032;
    exp_words.push_back({32'hE331_0310, wd});
    wait_words("t5_post_rst_timeout", 40);

    // T6: arb_en low stops grants, partial word still flushes
    do_reset();
    wd = '0;
    for (int k = 0; k < 2; k++) begin
      src_q[1].push_back(32'hF100_0000 | 32'(k));
      exp_ack.push_back(1);
      wd[k] = 32'hF100_0000 | 32'(k);
    end
    exp_words.push_back({32'hEFFF_FF11, wd});
    wait_acks("t6_ack_timeout", 2, 20);
    en_drv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      src_q[0].push_back(32'hF000_0000 | 32'(k));
      src_q[3].push_back(32'hF300_0000 | 32'(k));
    end
    wait_words("t6_flush_timeout", 120);
    tick();
    check_eq("t6_no_grant_ack", 256'(src_ack), 256'd0);
    check_eq("t6_total_acks", 256'(acks_seen), 256'd2);
    check_eq("t6_stat_words", 256'(stat_words), 256'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
